// File: rtl/pe_feeder.sv
// pe_feeder: operand-pair FIFO and burst sequencer that feeds one systolic PE and collects its dot-product result
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   h_a_data, h_b_data, h_we    host operand pair and push strobe (dropped while h_full)
//   h_full, h_count             FIFO full flag and occupancy
//   go, max_cntr                burst request and burst length N (latched on accept)
//   busy, done, err             burst active, one-cycle result-valid pulse, one-cycle reject/timeout pulse
//   res, res_sat                captured PE sum and saturation flag
//   pe_start, pe_a, pe_b,       PE operand-write side: start pulse, operands and write enables,
//   pe_awe, pe_bwe, pe_max_cntr latched burst length
//   pe_aff, pe_bff              PE a/b-side full flags (backpressure)
//   pe_se, pe_s, pe_sat         PE sum-valid, sum and saturation flag
module pe_feeder #(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int TMO   = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] h_a_data,
    input  logic [DW-1:0] h_b_data,
    input  logic          h_we,
    output logic          h_full,
    output logic [AW:0]   h_count,
    input  logic          go,
    input  logic [7:0]    max_cntr,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] res,
    output logic          res_sat,
    output logic          err,
    output logic          pe_start,
    output logic [DW-1:0] pe_a,
    output logic [DW-1:0] pe_b,
    output logic          pe_awe,
    output logic          pe_bwe,
    output logic [7:0]    pe_max_cntr,
    input  logic          pe_aff,
    input  logic          pe_bff,
    input  logic          pe_se,
    input  logic [DW-1:0] pe_s,
    input  logic          pe_sat
);
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_WAIT_SE, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [2*DW-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr, r_rd;
    logic [7:0]      r_sent;
    logic [TW-1:0]   r_tmo;
    logic [AW:0]     w_count;
    logic            w_push, w_pop, w_last, w_go, w_go_ok, w_capture, w_timeout;

    assign w_push    = h_we && !h_full;
    assign w_pop     = r_state == S_STREAM && !pe_aff && !pe_bff && r_sent < pe_max_cntr;
    assign w_last    = w_pop && r_sent + 8'd1 == pe_max_cntr;
    assign w_go      = r_state == S_IDLE && go;
    assign w_go_ok   = w_go && max_cntr != 8'd0 && 32'(h_count) >= 32'(max_cntr);
    assign w_capture = r_state == S_WAIT_SE && pe_se;
    // Compare against TMO-1: err is registered, so it lands exactly TMO cycles after entering WAIT_SE
    assign w_timeout = r_state == S_WAIT_SE && !pe_se && r_tmo == TW'(TMO - 1);
    assign w_count   = h_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_go_ok ? S_START : S_IDLE;
            S_START:   w_next = S_STREAM;
            S_STREAM:  w_next = w_last ? S_WAIT_SE : S_STREAM;
            S_WAIT_SE: w_next = w_capture ? S_DONE : w_timeout ? S_IDLE : S_WAIT_SE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Storage needs no reset: the pointers and count alone define what is valid
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {h_a_data, h_b_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_sent      <= '0;
            r_tmo       <= '0;
            h_count     <= '0;
            h_full      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            res         <= '0;
            res_sat     <= 1'b0;
            pe_start    <= 1'b0;
            pe_a        <= '0;
            pe_b        <= '0;
            pe_awe      <= 1'b0;
            pe_bwe      <= 1'b0;
            pe_max_cntr <= '0;
        end else begin
            r_wr     <= r_wr + AW'(w_push);
            r_rd     <= r_rd + AW'(w_pop);
            h_count  <= w_count;
            h_full   <= w_count == (AW+1)'(DEPTH);
            r_sent   <= w_go_ok ? 8'd0 : r_sent + 8'(w_pop);
            r_tmo    <= r_state == S_WAIT_SE ? r_tmo + TW'(1) : '0;
            busy     <= w_next != S_IDLE;
            done     <= w_capture;
            err      <= (w_go && !w_go_ok) || w_timeout;
            pe_start <= w_go_ok;
            pe_awe   <= w_pop;
            pe_bwe   <= w_pop;
            // Operands are forced to zero on idle cycles so the PE never sees stale data
            pe_a     <= w_pop ? r_mem[r_rd][2*DW-1:DW] : '0;
            pe_b     <= w_pop ? r_mem[r_rd][DW-1:0] : '0;
            if (w_go_ok) pe_max_cntr <= max_cntr;
            if (w_capture) begin
                res     <= pe_s;
                res_sat <= pe_sat;
            end
        end
    end
endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: randomized scenario bench for pe_feeder, checked against a queue-based FIFO/burst reference model
module tb_pe_feeder;
    localparam int DW = 16, DEPTH = 16, AW = 4, TMO = 255;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [DW-1:0] h_a_data = '0, h_b_data = '0, pe_s = '0;
    logic          h_we = 1'b0, go = 1'b0, pe_aff = 1'b0, pe_bff = 1'b0, pe_se = 1'b0, pe_sat = 1'b0;
    logic [7:0]    max_cntr = '0;
    logic [DW-1:0] res, pe_a, pe_b;
    logic [7:0]    pe_max_cntr;
    logic [AW:0]   h_count;
    logic          h_full, busy, done, res_sat, err, pe_start, pe_awe, pe_bwe;

    int n_chk = 0, n_fail = 0, cyc = 0, g = 0, bad_we = 0;
    int aff_from = -1, aff_to = -1, se_at = -1, se_early = -1, probe_cyc = -1;
    bit stall_b = 1'b0;
    logic probe_full = 1'b1;
    logic [2*DW-1:0] mq[$];
    logic [DW-1:0] wr_a[$], wr_b[$];
    int wr_cyc[$], start_cyc[$], done_cyc[$], err_cyc[$];

    always #5 clk = ~clk;

    pe_feeder #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .h_a_data(h_a_data), .h_b_data(h_b_data), .h_we(h_we),
        .h_full(h_full), .h_count(h_count),
        .go(go), .max_cntr(max_cntr),
        .busy(busy), .done(done), .res(res), .res_sat(res_sat), .err(err),
        .pe_start(pe_start), .pe_a(pe_a), .pe_b(pe_b), .pe_awe(pe_awe), .pe_bwe(pe_bwe),
        .pe_max_cntr(pe_max_cntr),
        .pe_aff(pe_aff), .pe_bff(pe_bff), .pe_se(pe_se), .pe_s(pe_s), .pe_sat(pe_sat)
    );

    // One clock: sample outputs 1 ns after the edge, log PE-side events, drive the PE model for the new cycle
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (pe_awe) begin
            wr_a.push_back(pe_a);
            wr_b.push_back(pe_b);
            wr_cyc.push_back(cyc);
        end
        if (pe_awe !== pe_bwe || (!pe_awe && (pe_a !== '0 || pe_b !== '0))) bad_we++;
        if (pe_start) start_cyc.push_back(cyc);
        if (done) done_cyc.push_back(cyc);
        if (err) err_cyc.push_back(cyc);
        if (cyc == probe_cyc) probe_full = h_full;
        pe_aff = (cyc >= aff_from && cyc < aff_to) && !stall_b;
        pe_bff = (cyc >= aff_from && cyc < aff_to) && stall_b;
        pe_se  = (cyc == se_at) || (cyc == se_early);
    endtask

    task automatic clear_caps();
        wr_a.delete(); wr_b.delete(); wr_cyc.delete();
        start_cyc.delete(); done_cyc.delete(); err_cyc.delete();
        bad_we = 0; aff_from = -1; aff_to = -1; se_at = -1; se_early = -1; probe_cyc = -1;
    endtask

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
        h_a_data = a; h_b_data = b; h_we = 1'b1;
        if (mq.size() < DEPTH) mq.push_back({a, b});
        step();
        h_we = 1'b0;
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) push(16'($urandom()), 16'($urandom()));
    endtask

    // Reference dot product of the next n queued pairs, wrapped to DW bits
    function automatic logic [DW-1:0] dot(input int n);
        int acc = 0;
        for (int i = 0; i < n && i < mq.size(); i++)
            acc += int'($signed(mq[i][2*DW-1:DW])) * int'($signed(mq[i][DW-1:0]));
        return DW'(acc);
    endfunction

    // Number of delivered pairs that differ from the model's next n pairs; consumes them from the model
    function automatic int count_bad(input int n);
        int bad = 0;
        if (wr_a.size() != n) bad++;
        for (int i = 0; i < n; i++) begin
            if (mq.size() == 0 || i >= wr_a.size() || {wr_a[i], wr_b[i]} !== mq[0]) bad++;
            if (mq.size() != 0) void'(mq.pop_front());
        end
        return bad;
    endfunction

    task automatic run_burst(input int n, input int win_rel, input int win_len, input bit use_b,
                             input int se_rel, input int se_early_rel, input logic [DW-1:0] s_val,
                             input logic sat_val, input int budget);
        clear_caps();
        pe_s = s_val; pe_sat = sat_val; stall_b = use_b;
        go = 1'b1; max_cntr = 8'(n); g = cyc;
        if (win_len > 0) begin
            aff_from = g + win_rel;
            aff_to   = g + win_rel + win_len;
        end
        if (se_rel >= 0) se_at = g + se_rel;
        if (se_early_rel >= 0) se_early = g + se_early_rel;
        probe_cyc = g + 3;
        step();
        go = 1'b0;
        for (int k = 0; k < budget && busy; k++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_chk++;
        if ({h_full, h_count, busy, done, res, res_sat, err, pe_start, pe_a, pe_b, pe_awe, pe_bwe, pe_max_cntr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b h_count=%0d res=%h pe_awe=%b, want all zero", busy, h_count, res, pe_awe);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int bad;
        push(1, 5); push(2, 6); push(3, 7); push(4, 8);
        n_chk++;
        if (h_count !== 5'd4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", h_count); end
        run_burst(4, 0, 0, 1'b0, 9, 4, 16'd70, 1'b0, 40);
        n_chk++;
        if (start_cyc.size() != 1 || start_cyc[0] != g + 1) begin
            n_fail++; $display("FAIL basic_start: got %0d pulses first at +%0d, want 1 at +1", start_cyc.size(), start_cyc.size() ? start_cyc[0] - g : -1);
        end
        n_chk++;
        if (pe_max_cntr !== 8'd4) begin n_fail++; $display("FAIL basic_max_cntr: got %0d want 4", pe_max_cntr); end
        n_chk++;
        if (wr_cyc.size() != 4 || wr_cyc[0] != g + 3 || wr_cyc[3] != g + 6) begin
            n_fail++; $display("FAIL basic_write_timing: got %0d writes first +%0d, want 4 writes at +3..+6", wr_cyc.size(), wr_cyc.size() ? wr_cyc[0] - g : -1);
        end
        bad = count_bad(4);
        n_chk++;
        if (bad != 0) begin n_fail++; $display("FAIL basic_data: got %0d bad pairs want 0", bad); end
        n_chk++;
        if (res !== 16'd70 || res_sat !== 1'b0) begin n_fail++; $display("FAIL basic_res: got %0d sat=%b want 70 sat=0", res, res_sat); end
        n_chk++;
        if (done_cyc.size() != 1 || done_cyc[0] != g + 10) begin
            n_fail++; $display("FAIL basic_done: got %0d pulses first +%0d, want 1 at +10", done_cyc.size(), done_cyc.size() ? done_cyc[0] - g : -1);
        end
        n_chk++;
        if (busy !== 1'b0 || h_count !== '0 || err_cyc.size() != 0 || bad_we != 0) begin
            n_fail++; $display("FAIL basic_after: got busy=%b count=%0d errs=%0d we_faults=%0d want 0 0 0 0", busy, h_count, err_cyc.size(), bad_we);
        end
    endtask

    task automatic test_backpressure();
        int bad, idle;
        push(1, 5); push(2, 6); push(3, 7); push(4, 8);
        run_burst(4, 5, 2, 1'b0, 11, -1, 16'd70, 1'b0, 40);
        idle = wr_cyc.size() == 4 ? wr_cyc[3] - wr_cyc[0] + 1 - 4 : -1;
        n_chk++;
        if (idle != 2) begin n_fail++; $display("FAIL bp_idle_cycles: got %0d want 2", idle); end
        bad = count_bad(4);
        n_chk++;
        if (bad != 0 || bad_we != 0) begin n_fail++; $display("FAIL bp_data: got %0d bad pairs %0d we faults want 0", bad, bad_we); end
        n_chk++;
        if (res !== 16'd70 || done_cyc.size() != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_result: got res=%0d dones=%0d busy=%b want 70 1 0", res, done_cyc.size(), busy);
        end
    endtask

    task automatic test_insufficient();
        int bad;
        logic [DW-1:0] s;
        push_rand(3);
        for (int k = 0; k < 2; k++) begin
            clear_caps();
            go = 1'b1; max_cntr = k == 0 ? 8'd4 : 8'd0; g = cyc;
            step();
            go = 1'b0;
            repeat (3) step();
            n_chk++;
            if (err_cyc.size() != 1 || err_cyc[0] != g + 1 || start_cyc.size() != 0) begin
                n_fail++; $display("FAIL insuff_err_N%0d: got %0d err pulses %0d starts, want 1 at +1 and 0", max_cntr, err_cyc.size(), start_cyc.size());
            end
            n_chk++;
            if (h_count !== 5'd3 || busy !== 1'b0) begin n_fail++; $display("FAIL insuff_count_N%0d: got count=%0d busy=%b want 3 0", max_cntr, h_count, busy); end
        end
        s = dot(3);
        run_burst(3, 0, 0, 1'b0, 8, -1, s, 1'b0, 40);
        bad = count_bad(3);
        n_chk++;
        if (bad != 0 || res !== s) begin n_fail++; $display("FAIL insuff_drain: got %0d bad res=%h want 0 res=%h", bad, res, s); end
    endtask

    task automatic test_fifo_wrap();
        int bad;
        logic [DW-1:0] s;
        for (int i = 0; i < 17; i++) begin
            push(16'($urandom()), 16'($urandom()));
            if (i == 14) begin
                n_chk++;
                if (h_full !== 1'b0) begin n_fail++; $display("FAIL full_at15: got %b want 0", h_full); end
            end
            if (i == 15) begin
                n_chk++;
                if (h_full !== 1'b1) begin n_fail++; $display("FAIL full_at16: got %b want 1", h_full); end
            end
        end
        n_chk++;
        if (h_count !== 5'd16 || h_full !== 1'b1) begin n_fail++; $display("FAIL full_drop17: got count=%0d full=%b want 16 1", h_count, h_full); end
        s = dot(8);
        run_burst(8, 0, 0, 1'b0, 13, -1, s, 1'b0, 60);
        bad = count_bad(8);
        n_chk++;
        if (bad != 0 || res !== s) begin n_fail++; $display("FAIL wrap_burst1: got %0d bad res=%h want 0 res=%h", bad, res, s); end
        push_rand(8);
        n_chk++;
        if (h_count !== 5'd16 || h_full !== 1'b1) begin n_fail++; $display("FAIL wrap_refill: got count=%0d full=%b want 16 1", h_count, h_full); end
        s = dot(8);
        run_burst(8, 6, 3, 1'b1, 16, -1, s, 1'b0, 60);
        n_chk++;
        if (wr_cyc.size() != 8 || wr_cyc[7] - wr_cyc[0] + 1 - 8 != 3) begin
            n_fail++; $display("FAIL wrap_bff_stall: got %0d writes, want 8 with 3 idle cycles", wr_cyc.size());
        end
        bad = count_bad(8);
        n_chk++;
        if (bad != 0 || res !== s || bad_we != 0) begin n_fail++; $display("FAIL wrap_burst2: got %0d bad res=%h want 0 res=%h", bad, res, s); end
        s = dot(8);
        run_burst(8, 0, 0, 1'b0, 13, -1, s, 1'b0, 60);
        bad = count_bad(8);
        n_chk++;
        if (bad != 0 || res !== s) begin n_fail++; $display("FAIL wrap_burst3: got %0d bad res=%h want 0 res=%h", bad, res, s); end
        push_rand(16);
        s = dot(16);
        run_burst(16, 0, 0, 1'b0, 21, -1, s, 1'b0, 80);
        n_chk++;
        if (probe_full !== 1'b0) begin n_fail++; $display("FAIL full_burst_hfull: got %b after first pop want 0", probe_full); end
        n_chk++;
        if (wr_cyc.size() != 16 || wr_cyc[15] != g + 18) begin
            n_fail++; $display("FAIL full_burst_timing: got %0d writes, want 16 ending at +18", wr_cyc.size());
        end
        bad = count_bad(16);
        n_chk++;
        if (bad != 0 || res !== s || h_count !== '0) begin n_fail++; $display("FAIL full_burst_data: got %0d bad count=%0d want 0 0", bad, h_count); end
    endtask

    task automatic test_saturation();
        int bad;
        push_rand(2);
        run_burst(2, 0, 0, 1'b0, 7, -1, 16'h7FFF, 1'b1, 30);
        bad = count_bad(2);
        n_chk++;
        if (res !== 16'h7FFF || res_sat !== 1'b1 || bad != 0) begin
            n_fail++; $display("FAIL sat_capture: got res=%h sat=%b bad=%0d want 7fff 1 0", res, res_sat, bad);
        end
        pe_s = 16'h0001; pe_sat = 1'b0;
        repeat (5) step();
        n_chk++;
        if (res !== 16'h7FFF || res_sat !== 1'b1) begin n_fail++; $display("FAIL sat_hold: got res=%h sat=%b want 7fff 1", res, res_sat); end
    endtask

    task automatic test_timeout();
        int bad;
        push_rand(2);
        run_burst(2, 0, 0, 1'b0, -1, -1, 16'h1234, 1'b0, TMO + 20);
        n_chk++;
        if (err_cyc.size() != 1 || err_cyc[0] != g + 4 + TMO) begin
            n_fail++; $display("FAIL timeout_err: got %0d pulses first +%0d, want 1 at +%0d", err_cyc.size(), err_cyc.size() ? err_cyc[0] - g : -1, 4 + TMO);
        end
        n_chk++;
        if (busy !== 1'b0 || done_cyc.size() != 0 || res !== 16'h7FFF || res_sat !== 1'b1) begin
            n_fail++; $display("FAIL timeout_state: got busy=%b dones=%0d res=%h sat=%b want 0 0 7fff 1", busy, done_cyc.size(), res, res_sat);
        end
        bad = count_bad(2);
        n_chk++;
        if (bad != 0) begin n_fail++; $display("FAIL timeout_data: got %0d bad pairs want 0", bad); end
    endtask

    task automatic test_reset_mid();
        int bad;
        logic [DW-1:0] s;
        push_rand(6);
        clear_caps();
        go = 1'b1; max_cntr = 8'd6; g = cyc;
        step();
        go = 1'b0;
        repeat (3) step();
        n_chk++;
        if (pe_awe !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_streaming: got awe=%b busy=%b want 1 1", pe_awe, busy); end
        rst_n = 1'b0;
        step();
        n_chk++;
        if ({h_full, h_count, busy, done, res, res_sat, err, pe_start, pe_a, pe_b, pe_awe, pe_bwe, pe_max_cntr} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: got busy=%b h_count=%0d awe=%b res=%h want all zero", busy, h_count, pe_awe, res);
        end
        rst_n = 1'b1;
        mq.delete();
        step();
        push_rand(3);
        s = dot(3);
        run_burst(3, 0, 0, 1'b0, 8, -1, s, 1'b0, 40);
        bad = count_bad(3);
        n_chk++;
        if (bad != 0 || res !== s || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_recover: got %0d bad res=%h want 0 res=%h", bad, res, s); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_insufficient();
        test_fifo_wrap();
        test_saturation();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
